// File: rtl/operand_streamer.sv
// operand_streamer: packs 16 streamed operand words onto two core operand buses,
// holds them through the core latency, and returns the captured sum on a valid/ready port.
module operand_streamer #(
    parameter int WORD_W   = 16,
    parameter int N_WORDS  = 8,
    parameter int RES_W    = 25,
    parameter int CALC_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    output logic [WORD_W*N_WORDS-1:0] calc_a,
    output logic [WORD_W*N_WORDS-1:0] calc_b,
    input  logic [RES_W-1:0]          calc_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [RES_W-1:0]          res_data,
    output logic [15:0]               op_count
);
    localparam int IW = $clog2(2 * N_WORDS);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, HOLD} state_t;

    state_t        state, state_n;
    logic [IW-1:0] word_idx;
    logic [3:0]    cnt;
    logic          xfer, last, sample, accept;

    assign xfer   = state == LOAD && in_valid && in_ready;
    assign last   = word_idx == IW'(2 * N_WORDS - 1);
    assign sample = state == WAIT && cnt == 4'(CALC_LAT);
    assign accept = state == HOLD && res_ready;

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = xfer && last ? ISSUE : LOAD;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = sample ? HOLD : WAIT;
            HOLD:    state_n = accept ? LOAD : HOLD;
            default: state_n = LOAD;
        endcase
    end

    // word_idx msb selects bus B; it wraps to 0 naturally after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            word_idx  <= '0;
            cnt       <= '0;
            calc_a    <= '0;
            calc_b    <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            op_count  <= '0;
        end else begin
            state    <= state_n;
            in_ready <= state_n == LOAD;
            if (xfer) begin
                word_idx <= word_idx + 1'b1;
                if (word_idx[IW-1])
                    calc_b[word_idx[IW-2:0] * WORD_W +: WORD_W] <= in_data;
                else
                    calc_a[word_idx[IW-2:0] * WORD_W +: WORD_W] <= in_data;
            end
            if (state == ISSUE)
                cnt <= 4'd1;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (sample) begin
                res_data  <= calc_result;
                res_valid <= 1'b1;
            end
            if (accept) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_operand_streamer.sv
// tb_operand_streamer: directed transactions with a queue-based scoreboard; a forked monitor
// checks bus packing at ISSUE, result latency, and each result handshake.
module tb_operand_streamer;
    typedef struct {logic [127:0] a; logic [127:0] b;} bus_t;
    typedef struct {logic [24:0] d; logic [15:0] ops;} res_t;

    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic [127:0] calc_a, calc_b;
    logic [24:0]  calc_result;
    logic         res_valid;
    logic         res_ready = 0;
    logic [24:0]  res_data;
    logic [15:0]  op_count;

    logic [24:0]  stub = '0;
    logic [15:0]  ops = '0;
    int           nx = 0;
    int           since = -1;
    int           total = 0;
    int           bad = 0;
    bus_t         bus_q[$];
    res_t         res_q[$];

    operand_streamer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .calc_a(calc_a), .calc_b(calc_b), .calc_result(calc_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // core stub: drives the sum only in the cycle the streamer should sample it
    assign calc_result = since == 3 ? stub : '0;

    always @(posedge clk) begin
        if (rst) begin
            nx    <= 0;
            since <= -1;
        end else begin
            if (in_valid && in_ready) nx <= nx == 15 ? 0 : nx + 1;
            since <= (in_valid && in_ready && nx == 15) ? 0 :
                     (since >= 0 && since < 100) ? since + 1 : since;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        bus_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && since == 0) begin
                if (bus_q.size() == 0) chk("bus_q_underflow", 0, 1);
                else begin
                    e = bus_q.pop_front();
                    chk("issue_a", calc_a, e.a);
                    chk("issue_b", calc_b, e.b);
                end
                chk("issue_ready", in_ready, 0);
            end
            if (!rst && since == 3) chk("lat_early", res_valid, 0);
            if (!rst && since == 4) chk("lat_rise", res_valid, 1);
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) chk("res_q_underflow", 0, 1);
                else begin
                    r = res_q.pop_front();
                    chk("res_data", res_data, r.d);
                    chk("res_ops", op_count, r.ops);
                end
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        logic got = 0;
        in_valid = 1;
        in_data  = w;
        for (int i = 0; i < 50 && !got; i++) begin
            got = in_ready;
            tick();
        end
        chk("word_timeout", got, 1);
    endtask

    task automatic send_txn(input logic [15:0] base, input bit gap, input logic [24:0] res, input bit push_res);
        bus_t e;
        for (int k = 0; k < 8; k++) begin
            e.a[k*16 +: 16] = base + 16'(k);
            e.b[k*16 +: 16] = base + 16'(k + 8);
        end
        bus_q.push_back(e);
        if (push_res) res_q.push_back('{d: res, ops: ops});
        stub = res;
        for (int k = 0; k < 16; k++) begin
            if (gap && k > 0) begin
                in_valid = 0;
                tick();
            end
            send_word(base + 16'(k));
        end
        in_valid = 0;
    endtask

    task automatic recv();
        for (int i = 0; i < 200 && !res_valid; i++) tick();
        chk("res_timeout", res_valid, 1);
        res_ready = 1;
        tick();
        res_ready = 0;
        ops++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        // reset state, then reset mid-load after 5 words
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_a", calc_a, 0);
        chk("rst_b", calc_b, 0);
        chk("rst_ops", op_count, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_rd", res_data, 0);
        rst = 0;
        tick();
        chk("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) send_word(16'hAAA0 + 16'(i));
        in_valid = 0;
        rst = 1;
        tick();
        chk("midload_ready", in_ready, 0);
        tick();
        chk("midload_a", calc_a, 0);
        rst = 0;
        tick();
        send_word(16'h1234);
        in_valid = 0;
        chk("lane0_after_rst", calc_a, 128'h1234);
        rst = 1;
        tick();
        rst = 0;
        tick();
        // back-to-back packing and latency
        send_txn(16'h0000, 0, 25'h0ABCDE, 1);
        recv();
        chk("pack_a", calc_a, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("pack_b", calc_b, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
        chk("ops_1", op_count, 1);
        // result back-pressure with a word pending at the source
        send_txn(16'h0100, 0, 25'h1FFFFFF, 1);
        for (int i = 0; i < 200 && !res_valid; i++) tick();
        in_valid = 1;
        in_data  = 16'h2000;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready", in_ready, 0);
            chk("bp_data", res_data, 25'h1FFFFFF);
            chk("bp_ops", op_count, 1);
            tick();
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        ops++;
        chk("bp_ops_after", op_count, 2);
        chk("bp_ready_after", in_ready, 1);
        chk("bp_rv_after", res_valid, 0);
        // gapped input; its first word is the one left pending above
        send_txn(16'h2000, 1, 25'h0000155, 1);
        recv();
        chk("gap_a", calc_a, 128'h2007_2006_2005_2004_2003_2002_2001_2000);
        // op_count wrap
        force dut.op_count = 16'hFFFF;
        tick();
        release dut.op_count;
        ops = 16'hFFFF;
        chk("preload", op_count, 16'hFFFF);
        send_txn(16'h4000, 0, 25'h1000001, 1);
        recv();
        chk("wrap", op_count, 0);
        // reset while waiting on the core
        send_txn(16'h5000, 0, 25'h0000123, 0);
        tick();
        rst = 1;
        tick();
        chk("wait_rst_rv", res_valid, 0);
        chk("wait_rst_ready", in_ready, 0);
        tick();
        rst = 0;
        tick();
        ops = 0;
        chk("wait_rst_load", in_ready, 1);
        repeat (6) tick();
        chk("wait_rst_no_res", res_valid, 0);
        send_txn(16'h6000, 0, 25'h00FEDCB, 1);
        recv();
        chk("final_ops", op_count, 1);
        repeat (3) tick();
        chk("bus_q_left", bus_q.size(), 0);
        chk("res_q_left", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
